// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response and data-memory handshake bundle for lsu_mem_ctrl.
// slave = controller side, master = core plus memory environment.
interface lsu_mem_ctrl_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic        o_trap;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rdata, o_trap,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req_valid, i_req_we, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rdata, o_trap,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer to a word-wide single-port memory; one request in flight, ready only in IDLE.
// Latency from accept: trap 1, load/SW 2, SB/SH 4 cycles with zero-wait memory; memory waits bounded by TIMEOUT.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input logic         i_clk,
  input logic         i_rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_n;
  logic        we_q, we_n;
  logic [2:0]  funct3_q, funct3_n;
  logic [1:0]  addr_lo_q, addr_lo_n;
  logic [31:0] wdata_q, wdata_n;
  logic [7:0]  cnt_q, cnt_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [31:0] rdata_q, rdata_n;
  logic        trap_q, trap_n;
  logic        mem_req_q, mem_req_n;
  logic        mem_we_q, mem_we_n;
  logic [31:0] mem_addr_q, mem_addr_n;
  logic [31:0] mem_wdata_q, mem_wdata_n;
  logic [7:0]  cnt_inc;

  function automatic logic is_illegal(logic we, logic [2:0] f3, logic [1:0] a);
    logic bad_code;
    logic misaligned;
    if (we) bad_code = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    bad_code = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                         f3 == 3'b100 || f3 == 3'b101);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_code || misaligned;
  endfunction

  function automatic logic [31:0] load_ext(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // keep-mask bit=1 preserves the old memory bit; funct3[0] selects half vs byte
  function automatic logic [31:0] merge(logic [2:0] f3, logic [1:0] a, logic [31:0] old_w,
                                        logic [31:0] d);
    logic [31:0] keep;
    logic [31:0] lane;
    if (f3[0]) begin
      keep = a[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      lane = {16'b0, d[15:0]};
    end else begin
      keep = ~(32'h0000_00FF << {a, 3'b000});
      lane = {24'b0, d[7:0]};
    end
    return (old_w & keep) | (lane << {a, 3'b000});
  endfunction

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_n     = state_q;
    we_n        = we_q;
    funct3_n    = funct3_q;
    addr_lo_n   = addr_lo_q;
    wdata_n     = wdata_q;
    cnt_n       = cnt_q;
    rsp_valid_n = 1'b0;
    rdata_n     = rdata_q;
    trap_n      = trap_q;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          we_n       = bus.i_req_we;
          funct3_n   = bus.i_funct3;
          addr_lo_n  = bus.i_addr[1:0];
          wdata_n    = bus.i_wdata;
          mem_addr_n = {bus.i_addr[31:2], 2'b00};
          cnt_n      = 8'd0;
          if (is_illegal(bus.i_req_we, bus.i_funct3, bus.i_addr[1:0])) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            trap_n      = 1'b1;
            rdata_n     = 32'd0;
          end else if (bus.i_req_we && bus.i_funct3 == 3'b010) begin
            state_n     = WR;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_wdata_n = bus.i_wdata;
          end else begin
            state_n   = RD;
            mem_req_n = 1'b1;
            mem_we_n  = 1'b0;
          end
        end
      end

      RD: begin
        if (bus.i_mem_ack) begin
          mem_req_n = 1'b0;
          if (!we_q) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            trap_n      = 1'b0;
            rdata_n     = load_ext(funct3_q, addr_lo_q, bus.i_mem_rdata);
          end else begin
            // request stays low for one cycle in WR before the write is issued
            state_n     = WR;
            mem_we_n    = 1'b1;
            mem_wdata_n = merge(funct3_q, addr_lo_q, bus.i_mem_rdata, wdata_q);
            cnt_n       = 8'd0;
          end
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == TMO) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            trap_n      = 1'b1;
            rdata_n     = 32'd0;
            mem_req_n   = 1'b0;
          end
        end
      end

      WR: begin
        if (!mem_req_q) begin
          mem_req_n = 1'b1;
        end else if (bus.i_mem_ack) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          trap_n      = 1'b0;
          rdata_n     = 32'd0;
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == TMO) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            trap_n      = 1'b1;
            rdata_n     = 32'd0;
            mem_req_n   = 1'b0;
            mem_we_n    = 1'b0;
          end
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      wdata_q     <= 32'd0;
      cnt_q       <= 8'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      trap_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_n;
      we_q        <= we_n;
      funct3_q    <= funct3_n;
      addr_lo_q   <= addr_lo_n;
      wdata_q     <= wdata_n;
      cnt_q       <= cnt_n;
      rsp_valid_q <= rsp_valid_n;
      rdata_q     <= rdata_n;
      trap_q      <= trap_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
    end
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_trap      = trap_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: zero-wait memory responder, write capture, timeout and reset cases.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        ack_en  = 1'b1;
  logic [31:0] mem_word = 32'd0;

  int          wr_cnt  = 0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  // memory acknowledges in the first request cycle when enabled
  assign bus.i_mem_ack   = ack_en && bus.o_mem_req;
  assign bus.i_mem_rdata = mem_word;

  always @(posedge clk) begin
    if (!rst && bus.o_mem_req && bus.o_mem_we && bus.i_mem_ack) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = bus.o_mem_addr;
      wr_data = bus.o_mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          lat;
  logic [15:0] req_hist;
  logic [15:0] we_hist;
  logic [31:0] rsp_rdata;
  logic        rsp_trap;

  // accept one request, then sample on falling edges until the response pulse
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit seen;
    seen     = 0;
    lat      = 0;
    req_hist = '0;
    we_hist  = '0;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_funct3    = f3;
    bus.i_addr      = addr;
    bus.i_wdata     = wdata;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    for (int n = 1; n < 16; n++) begin
      @(negedge clk);
      req_hist[n] = bus.o_mem_req;
      we_hist[n]  = bus.o_mem_we;
      if (bus.o_rsp_valid) begin
        lat       = n;
        rsp_rdata = bus.o_rdata;
        rsp_trap  = bus.o_trap;
        seen      = 1;
        break;
      end
    end
    if (!seen) check("rsp_never_seen", 32'd0, 32'd1);
  endtask

  int wr_before;

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = 1'b0;
    bus.i_funct3    = 3'd0;
    bus.i_addr      = 32'd0;
    bus.i_wdata     = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     32'(bus.o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_rdata",     bus.o_rdata,          32'd0);
    check("rst_trap",      32'(bus.o_trap),      32'd0);
    check("rst_mem_req",   32'(bus.o_mem_req),   32'd0);
    check("rst_mem_we",    32'(bus.o_mem_we),    32'd0);
    check("rst_mem_addr",  bus.o_mem_addr,       32'd0);
    check("rst_mem_wdata", bus.o_mem_wdata,      32'd0);
    rst = 1'b0;

    // loads from word 0x8765_4321
    mem_word = 32'h8765_4321;
    do_req(1'b0, 3'b010, 32'h100, 32'd0);
    check("lw_lat",   32'(lat),      32'd2);
    check("lw_rdata", rsp_rdata,     32'h8765_4321);
    check("lw_trap",  32'(rsp_trap), 32'd0);
    check("lw_req",   32'(req_hist), 32'h0002);
    @(negedge clk);
    check("rdata_hold", bus.o_rdata, 32'h8765_4321);
    check("rsp_pulse",  32'(bus.o_rsp_valid), 32'd0);
    do_req(1'b0, 3'b000, 32'h103, 32'd0);
    check("lb_rdata",  rsp_rdata, 32'hFFFF_FF87);
    do_req(1'b0, 3'b100, 32'h103, 32'd0);
    check("lbu_rdata", rsp_rdata, 32'h0000_0087);
    do_req(1'b0, 3'b001, 32'h102, 32'd0);
    check("lh_rdata",  rsp_rdata, 32'hFFFF_8765);
    do_req(1'b0, 3'b101, 32'h100, 32'd0);
    check("lhu_rdata", rsp_rdata, 32'h0000_4321);

    // sub-word stores: read, one idle cycle, write
    mem_word = 32'h1122_3344;
    do_req(1'b1, 3'b000, 32'h101, 32'h0000_00AB);
    check("sb_lat",     32'(lat),      32'd4);
    check("sb_req",     32'(req_hist), 32'h000A);
    check("sb_we",      32'(we_hist & req_hist), 32'h0008);
    check("sb_wr_addr", wr_addr,       32'h100);
    check("sb_wr_data", wr_data,       32'h1122_AB44);
    check("sb_rdata",   rsp_rdata,     32'd0);
    do_req(1'b1, 3'b001, 32'h102, 32'h0000_BEEF);
    check("sh_lat",     32'(lat),  32'd4);
    check("sh_wr_data", wr_data,   32'hBEEF_3344);
    wr_before = wr_cnt;
    do_req(1'b1, 3'b000, 32'h203, 32'h0000_0055);
    check("sb3_wr_addr", wr_addr, 32'h200);
    check("sb3_wr_data", wr_data, 32'h5522_3344);
    check("sb3_wr_cnt",  32'(wr_cnt - wr_before), 32'd1);

    // illegal requests trap without touching memory
    wr_before = wr_cnt;
    do_req(1'b1, 3'b010, 32'h102, 32'h1234_5678);
    check("sw_mis_lat",  32'(lat),      32'd1);
    check("sw_mis_trap", 32'(rsp_trap), 32'd1);
    check("sw_mis_req",  32'(req_hist), 32'd0);
    do_req(1'b0, 3'b001, 32'h101, 32'd0);
    check("lh_mis_lat",  32'(lat),      32'd1);
    check("lh_mis_trap", 32'(rsp_trap), 32'd1);
    check("lh_mis_req",  32'(req_hist), 32'd0);
    do_req(1'b1, 3'b011, 32'h100, 32'd0);
    check("st_f3_lat",   32'(lat),      32'd1);
    check("st_f3_trap",  32'(rsp_trap), 32'd1);
    check("st_f3_req",   32'(req_hist), 32'd0);
    do_req(1'b0, 3'b110, 32'h100, 32'd0);
    check("ld_f3_trap",  32'(rsp_trap), 32'd1);
    check("trap_no_wr",  32'(wr_cnt - wr_before), 32'd0);

    // timeout with memory never acknowledging
    ack_en = 1'b0;
    do_req(1'b0, 3'b010, 32'h100, 32'd0);
    check("tmo_ld_lat",  32'(lat),      32'd5);
    check("tmo_ld_trap", 32'(rsp_trap), 32'd1);
    check("tmo_ld_req",  32'(req_hist), 32'h001E);
    wr_before = wr_cnt;
    do_req(1'b1, 3'b000, 32'h101, 32'h0000_00AB);
    check("tmo_sb_lat",  32'(lat),      32'd5);
    check("tmo_sb_trap", 32'(rsp_trap), 32'd1);
    check("tmo_sb_we",   32'(we_hist & req_hist), 32'd0);
    check("tmo_no_wr",   32'(wr_cnt - wr_before), 32'd0);

    // reset while a word store waits for ack
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_funct3    = 3'b010;
    bus.i_addr      = 32'h300;
    bus.i_wdata     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_pending", 32'({bus.o_mem_req, bus.o_mem_we}), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_mem_req", 32'(bus.o_mem_req),   32'd0);
    check("midrst_rsp",     32'(bus.o_rsp_valid), 32'd0);
    check("midrst_ready",   32'(bus.o_req_ready), 32'd1);
    @(negedge clk);
    check("midrst_rsp2",    32'(bus.o_rsp_valid), 32'd0);
    ack_en    = 1'b1;
    wr_before = wr_cnt;
    do_req(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D);
    check("post_sw_lat",  32'(lat),      32'd2);
    check("post_sw_trap", 32'(rsp_trap), 32'd0);
    check("post_sw_data", wr_data,       32'hCAFE_F00D);
    check("post_sw_addr", wr_addr,       32'h300);
    check("post_sw_cnt",  32'(wr_cnt - wr_before), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencing controller between the core's memory stage and a single-port, word-wide data memory.
- Accepts one load or store request at a time and checks alignment and funct3.
- Loads: issues a word read, then extracts and sign- or zero-extends the addressed byte or half.
- Stores: full-word stores write directly. Byte and half stores do a read-modify-write using a keep-mask (bit=1 keeps the old memory bit), the same lane convention as the store datapath.
- Returns a single-cycle response carrying read data or a trap.

Parameters:
TIMEOUT, 255, max cycles to wait for i_mem_ack in a memory state before aborting with a trap (8-bit counter; legal range 1..255)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_req_valid  input  1  core request valid
o_req_ready  output  1  controller can accept a request (high only in IDLE)
i_req_we  input  1  1=store, 0=load
i_funct3  input  3  RV32I width/sign code
i_addr  input  32  byte address
i_wdata  input  32  store data (low bits used for SB/SH)
o_rsp_valid  output  1  one-cycle response pulse
o_rdata  output  32  load result, valid with o_rsp_valid
o_trap  output  1  misaligned, illegal funct3 or timeout; qualified by o_rsp_valid
o_mem_req  output  1  memory access request
o_mem_we  output  1  memory write enable
o_mem_addr  output  32  word address {i_addr[31:2],2'b00}
o_mem_wdata  output  32  merged write word
i_mem_ack  input  1  memory completes the access this cycle
i_mem_rdata  input  32  read word, valid when i_mem_ack is high during a read

Behaviour:
- Reset values: state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rdata=0, o_trap=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, timeout counter=0.
- States: IDLE, RD, WR, RESP.
- IDLE, on i_req_valid & o_req_ready: latch we, funct3, addr, wdata, then:
  - Trap check first. Illegal cases: store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}; half access with addr[0]=1; word access with addr[1:0]!=0. Any illegal case -> RESP with trap=1 and no memory access.
  - Else SW -> WR with o_mem_wdata=wdata.
  - Else load, SB or SH -> RD.
- RD: o_mem_req=1, o_mem_we=0. On i_mem_ack:
  - Load -> RESP with o_rdata = extracted value:
    - LB/LBU: byte at addr[1:0].
    - LH/LHU: half at addr[1]; sign-extended for 000/001, zero-extended for 100/101.
    - LW: full word.
  - SB/SH -> WR with o_mem_wdata = (rdata & keep) | shifted.
    - SB keep masks, for addr[1:0]=00/01/10/11: FFFF_FF00 / FFFF_00FF / FF00_FFFF / 00FF_FFFF.
    - SH keep masks, for addr[1]=0/1: FFFF_0000 / 0000_FFFF.
    - shifted = data lane << (8*addr[1:0]).
- WR: o_mem_req=1, o_mem_we=1. On i_mem_ack -> RESP, trap=0, o_rdata=0.
- Memory handshake:
  - o_mem_addr, o_mem_we and o_mem_wdata are held stable while o_mem_req=1.
  - o_mem_req deasserts on the edge after the ack cycle.
  - RD->WR forces o_mem_req low for exactly one cycle between the two accesses.
- Timeout: counter clears on entry to RD/WR and increments each cycle without ack. If it reaches TIMEOUT -> RESP with trap=1, o_mem_req drops, and a store writes nothing.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. o_rdata and o_trap hold their values until the next response.
- Latency from accept edge to o_rsp_valid with zero-wait memory (ack in first request cycle):
  - trap: 1 cycle
  - load or SW: 2 cycles
  - SB/SH: 4 cycles (including the req-low gap)
- i_req_valid outside IDLE is ignored; the core must hold the request until o_req_ready.
- Reset mid-operation: next edge returns to IDLE with o_mem_req=0; no response is issued. A write in progress whose ack coincides with the reset cycle counts as completed by memory.

Test Plan:
- Load LW addr 0x100, memory word 0x8765_4321, ack immediate -> o_rsp_valid exactly 2 cycles after accept, o_rdata=0x8765_4321, o_trap=0.
- LB addr 0x103 and LBU addr 0x103, word 0x8765_4321 -> 0xFFFF_FF87 and 0x0000_0087; LH addr 0x102 -> 0xFFFF_8765.
- SB addr 0x101 data 0xAB, old word 0x1122_3344 -> read, one idle cycle, write addr 0x100 data 0x1122_AB44; SH addr 0x102 data 0xBEEF -> write 0xBEEF_3344.
- SW addr 0x102, LH addr 0x101, store funct3 011 -> each gives o_trap=1 one cycle after accept with o_mem_req never asserted.
- TIMEOUT=4, i_mem_ack held low -> o_mem_req for 4 cycles then o_rsp_valid with o_trap=1, no write issued.
- Assert i_rst during WR wait, then release -> o_mem_req low next cycle, no o_rsp_valid, o_req_ready=1, next SW completes normally.
